// File: rtl/fib_sched_pkg.sv
// ----------------------------------------------------------------------------
// fib_sched_pkg : shared FSM state type and req_n slice helper for fib_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fib_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GO     = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam int c_SLICE_BITS  = 512;
  localparam int c_SLICE_IDX_W = 9;
  localparam int c_SLICE_MAX_W = 32;

  // Returns bits [idx*width +: width] of a packed vector, zero-extended to 32.
  function automatic logic [31:0] req_n_slice(input logic [c_SLICE_BITS-1:0] packed_n,
                                              input int unsigned idx,
                                              input int unsigned width);
    logic [31:0] r;
    int unsigned pos;
    r = '0;
    for (int unsigned b = 0; b < c_SLICE_MAX_W; b++) begin
      pos = idx * width + b;
      if (b < width && pos < c_SLICE_BITS) r[b[4:0]] = packed_n[pos[c_SLICE_IDX_W-1:0]];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fib_sched_if.sv
// ----------------------------------------------------------------------------
// fib_sched_if : requester-side and core-side signals of the fib scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fib_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 16
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [OUTPUT_WIDTH-1:0]        resp_result;
  logic                           resp_overflow;
  logic                           resp_error;
  logic                           busy;
  logic                           fib_go;
  logic [INPUT_WIDTH-1:0]         fib_n;
  logic                           fib_done;
  logic [OUTPUT_WIDTH-1:0]        fib_result;
  logic                           fib_overflow;

  modport slave (
    input  req, req_n, fib_done, fib_result, fib_overflow,
    output ack, resp_valid, resp_result, resp_overflow, resp_error, busy, fib_go, fib_n
  );

  modport master (
    output req, req_n, fib_done, fib_result, fib_overflow,
    input  ack, resp_valid, resp_result, resp_overflow, resp_error, busy, fib_go, fib_n
  );
endinterface

`default_nettype wire

// File: rtl/fib_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, first request at/after pointer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                                 req_i,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   ptr_i,
  input  logic                                               enable_i,
  output logic [NUM_REQ-1:0]                                 grant_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   grant_idx_o,
  output logic                                               any_req_o
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic found;
  int   j;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (enable_i && !found && req_i[j[c_IDX_W-1:0]]) begin
        grant_o[j[c_IDX_W-1:0]] = 1'b1;
        grant_idx_o             = j[c_IDX_W-1:0];
        found                   = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/fib_sched.sv
// ----------------------------------------------------------------------------
// fib_sched : round-robin sharing of one Fibonacci core with done watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fib_sched
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  fib_sched_if.slave  bus
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [c_IDX_W-1:0]      owner_q, owner_d;
  logic [c_IDX_W-1:0]      ptr_q, ptr_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      rv_q, rv_d;
  logic [OUTPUT_WIDTH-1:0] res_q, res_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
  logic                    go_q, go_d;
  logic [INPUT_WIDTH-1:0]  n_q, n_d;

  logic [NUM_REQ-1:0]      win_grant;
  logic [c_IDX_W-1:0]      win_idx;
  logic                    any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .enable_i    (state_q == IDLE),
    .grant_o     (win_grant),
    .grant_idx_o (win_idx),
    .any_req_o   (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      go_q    <= go_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rv_d    = '0;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    go_d    = 1'b0;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = win_idx;
          n_d     = INPUT_WIDTH'(req_n_slice(c_SLICE_BITS'(bus.req_n), 32'(win_idx), INPUT_WIDTH));
          ack_d   = win_grant;
          state_d = GO;
        end
      end
      GO: begin
        go_d    = 1'b1;
        state_d = SETTLE;
      end
      // done may still be high from the previous job until the core sees go
      SETTLE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != c_CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (bus.fib_done) begin
          res_d   = bus.fib_result;
          ovf_d   = bus.fib_overflow;
          err_d   = 1'b0;
          rv_d    = NUM_REQ'(1) << owner_q;
          state_d = RESP;
        end else if (cnt_q == c_CNT_LAST) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          rv_d    = NUM_REQ'(1) << owner_q;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (owner_q == c_IDX_LAST) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack           = ack_q;
  assign bus.resp_valid    = rv_q;
  assign bus.resp_result   = res_q;
  assign bus.resp_overflow = ovf_q;
  assign bus.resp_error    = err_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.fib_go        = go_q;
  assign bus.fib_n         = n_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_sched.sv
// ----------------------------------------------------------------------------
// tb_fib_sched : random/directed bench for fib_sched with behavioural core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fib_sched;
  localparam int N  = 4;
  localparam int IW = 6;
  localparam int OW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_sched_if #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  fib_sched #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural core: clears done on go, raises it core_lat cycles later.
  int core_lat  = 1;
  bit core_hang = 1'b0;
  int ccnt      = 0;
  int cn        = 0;
  always @(posedge clk) begin
    if (bus.fib_go) begin
      bus.fib_done <= 1'b0;
      ccnt         <= core_hang ? 0 : core_lat;
      cn           <= int'(bus.fib_n);
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        bus.fib_done     <= 1'b1;
        bus.fib_result   <= OW'(fib(cn));
        bus.fib_overflow <= (fib(cn) >> OW) != 64'd0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [63:0] res;
    bit          ovf;
    bit          err;
    int          lat;
  } exp_t;

  exp_t expq[$];
  int   jobs[N][$];
  int   cur_n[N];
  int   ptr_m     = 0;
  int   cyc       = 0;
  int   go_cyc    = 0;
  int   go_n_exp  = 0;

  function automatic int winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  function automatic int jobs_left();
    int s = 0;
    for (int i = 0; i < N; i++) s += jobs[i].size();
    return s;
  endfunction

  task automatic post(input int i);
    cur_n[i] = jobs[i].pop_front();
    bus.req[i] = 1'b1;
    bus.req_n[i*IW +: IW] = IW'(cur_n[i]);
  endtask

  task automatic run(input int budget);
    int   c = 0;
    bit   fin = 1'b0;
    int   w;
    exp_t e;
    logic [63:0] f;
    for (int i = 0; i < N; i++)
      if (!bus.req[i] && jobs[i].size() > 0) post(i);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      c++;
      if (bus.ack != '0) begin
        w = winner(bus.req);
        check("ack_grant", 64'(bus.ack), (w < 0) ? 64'd0 : (64'd1 << w));
        if (w >= 0) begin
          f     = fib(cur_n[w]);
          e.idx = w;
          e.res = core_hang ? 64'd0 : (f & ((64'd1 << OW) - 1));
          e.ovf = core_hang ? 1'b0 : ((f >> OW) != 64'd0);
          e.err = core_hang;
          e.lat = core_hang ? TO + 1 : core_lat + 2;
          expq.push_back(e);
          go_n_exp = cur_n[w];
          if (jobs[w].size() > 0) post(w);
          else bus.req[w] = 1'b0;
        end
      end
      if (bus.fib_go) begin
        check("fib_n", 64'(bus.fib_n), 64'(go_n_exp));
        go_cyc = cyc;
      end
      if (bus.resp_valid != '0) begin
        if (expq.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          check("resp_valid", 64'(bus.resp_valid), 64'd1 << e.idx);
          check("resp_result", 64'(bus.resp_result), e.res);
          check("resp_overflow", 64'(bus.resp_overflow), 64'(e.ovf));
          check("resp_error", 64'(bus.resp_error), 64'(e.err));
          check("resp_latency", 64'(cyc - go_cyc), 64'(e.lat));
          ptr_m = (e.idx + 1) % N;
        end
      end
      if (bus.req == '0 && expq.size() == 0 && jobs_left() == 0) begin
        fin = 1'b1;
      end else if (c >= budget) begin
        check("run_pending_at_budget", 64'(expq.size() + jobs_left() + $countones(bus.req)), 64'd0);
        expq.delete();
        bus.req = '0;
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int nrv;
    rst              = 1'b1;
    bus.req          = '0;
    bus.req_n        = '0;
    bus.fib_done     = 1'b0;
    bus.fib_result   = '0;
    bus.fib_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_result", 64'(bus.resp_result), 64'd0);
    check("rst_resp_overflow", 64'(bus.resp_overflow), 64'd0);
    check("rst_resp_error", 64'(bus.resp_error), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_fib_go", 64'(bus.fib_go), 64'd0);
    check("rst_fib_n", 64'(bus.fib_n), 64'd0);
    rst = 1'b0;

    // all four requesters at once: grants 0,1,2,3 with 2,3,5,8
    core_lat = 1;
    jobs[0].push_back(3); jobs[1].push_back(4); jobs[2].push_back(5); jobs[3].push_back(6);
    run(300);

    // single job, fib(10)=55
    jobs[0].push_back(10);
    run(100);

    // overflow boundary at 16 bits
    core_lat = 3;
    jobs[1].push_back(24); jobs[1].push_back(25);
    run(200);

    // back-to-back, done still high through SETTLE
    core_lat = 1;
    jobs[0].push_back(6); jobs[0].push_back(7);
    run(200);

    for (int r = 0; r < 4; r++) begin
      core_lat = $urandom_range(1, 6);
      for (int i = 0; i < N; i++)
        if (i == r || $urandom_range(0, 1) == 1)
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) jobs[i].push_back($urandom_range(0, 30));
      run(2000);
    end

    // watchdog: core never answers, then recovers
    core_hang = 1'b1;
    jobs[2].push_back(9);
    run(200);
    core_hang = 1'b0;
    core_lat  = 2;
    jobs[2].push_back(11);
    run(200);

    // reset during WAIT, pointer must come back to 0
    core_hang = 1'b1;
    bus.req[3] = 1'b1;
    bus.req_n[3*IW +: IW] = IW'(20);
    k = 0;
    while (bus.ack == '0 && k < 20) begin @(negedge clk); k++; end
    check("rst_job_ack", 64'(bus.ack), 64'd1 << winner(bus.req));
    bus.req[3] = 1'b0;
    k = 0;
    while (!bus.fib_go && k < 20) begin @(negedge clk); k++; end
    check("rst_job_go", 64'(bus.fib_go), 64'd1);
    repeat (3) @(negedge clk);
    check("rst_job_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_fib_n", 64'(bus.fib_n), 64'd0);
    rst = 1'b0;
    nrv = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) nrv++;
    end
    check("rst_no_resp", 64'(nrv), 64'd0);
    core_hang = 1'b0;
    core_lat  = 1;
    ptr_m     = 0;
    expq.delete();
    jobs[2].push_back(5); jobs[3].push_back(8);
    run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Round-robin scheduler that shares one Fibonacci core (go/n → done/result/overflow handshake) among NUM_REQ requesters.
- Each requester posts an n with a level request, and is acknowledged when its job is launched.
- When the core finishes, the scheduler returns result and overflow to that requester only.
- Sits between the requester blocks and the single fib core instance. A watchdog recovers from a core that never signals done.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- INPUT_WIDTH, 6, width of n
- OUTPUT_WIDTH, 16, width of result
- TIMEOUT_CYCLES, 1024, max cycles to wait for done before flagging error (≥4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level, held until ack
- req_n  in  NUM_REQ*INPUT_WIDTH  packed n per requester; slice i = [i*INPUT_WIDTH +: INPUT_WIDTH]
- ack  out  NUM_REQ  one-hot, 1-cycle pulse: request i accepted
- resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: response for requester i
- resp_result  out  OUTPUT_WIDTH  result, valid with resp_valid
- resp_overflow  out  1  core overflow, valid with resp_valid
- resp_error  out  1  timeout flag, valid with resp_valid
- busy  out  1  high when not IDLE
- fib_go  out  1  core start pulse
- fib_n  out  INPUT_WIDTH  core operand, held stable from GO through WAIT
- fib_done  in  1  core done (level; core clears it the cycle after sampling go)
- fib_result  in  OUTPUT_WIDTH  core result
- fib_overflow  in  1  core overflow

Behaviour:
- Reset values:
  - ack=0, resp_valid=0, resp_result=0, resp_overflow=0, resp_error=0, busy=0, fib_go=0, fib_n=0.
  - State=IDLE; round-robin pointer=0; timeout counter=0.
- FSM states:
  - IDLE: if any req, the arbiter picks the winner, captured into owner. The winner is the first set bit at or after the pointer, wrapping. Latch fib_n=req_n[owner]. Pulse ack[owner] this cycle (registered, so visible the next cycle). Go to GO.
  - GO: fib_go=1 for exactly one cycle. Go to SETTLE.
  - SETTLE: ignore fib_done (it may still be high from the previous job). Clear the timeout counter. Go to WAIT.
  - WAIT: increment the counter each cycle.
    - If fib_done=1: register resp_result=fib_result, resp_overflow=fib_overflow, resp_error=0. Go to RESP.
    - Else if counter==TIMEOUT_CYCLES-1: resp_result=0, resp_overflow=0, resp_error=1. Go to RESP.
  - RESP: resp_valid[owner]=1 for one cycle. Pointer=(owner+1) mod NUM_REQ. Go to IDLE.
- Latency:
  - ack is high the cycle after the IDLE decision cycle.
  - fib_go is high the cycle after that.
  - resp_valid is high 1 cycle after the WAIT cycle in which done is seen.
  - Minimum 5 cycles from req to resp_valid with a 1-cycle core.
- Handshake rules:
  - Requester i must keep req[i] and its slice of req_n stable until ack[i].
  - After ack[i] it may drop req[i] or post a new job; a new job is not accepted before the current one's resp_valid.
  - A new job is served according to round-robin order.
  - req_n is sampled only in the IDLE decision cycle.
- Fairness: with all requesters active, grants rotate 0,1,2,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 jobs.
- Outputs:
  - resp_result, resp_overflow and resp_error hold their value until the next RESP.
  - ack and resp_valid are never multi-hot.
- Simultaneous events:
  - A new req arriving during GO..RESP waits in IDLE.
  - req dropping (protocol violation) after the decision cycle does not cancel the job.
  - fib_done high in GO or SETTLE is ignored.
- Timeout: the core is not reset by this block. The next job is still launched normally; system-level recovery is outside this block.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No resp_valid is issued for the aborted job. The pointer returns to 0.
- Width rules: owner is $clog2(NUM_REQ) bits. The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates, never wraps.

Decomposition:
- Package fib_sched_pkg holds:
  - the state enum typedef (IDLE, GO, SETTLE, WAIT, RESP), logic[2:0];
  - a function that extracts the req_n slice.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req, pointer, enable;
  - outputs: one-hot grant, grant index, any_req.
  - Purely combinational; the pointer register stays in fib_sched.

Test Plan (core with fib(0)=0, fib(1)=1, OUTPUT_WIDTH=16 unless noted):
- req[0]=1, n=10 → ack[0] one pulse; one fib_go pulse with fib_n=10; resp_valid[0] pulse, resp_result=55, resp_overflow=0, resp_error=0.
- req=4'b1111 with n=3,4,5,6, each held until ack → acks in order 0,1,2,3; resp_valid order 0,1,2,3 with results 2,3,5,8.
- OUTPUT_WIDTH=8:
  - n=13 → result 233, overflow=0.
  - n=14 → resp_overflow=1.
- Back-to-back jobs where fib_done is still high in SETTLE → second response uses the new result, not a stale one (n=6 then n=7 → 8 then 13).
- Core model never asserts done, TIMEOUT_CYCLES=16 → resp_error=1, resp_result=0 exactly 16 WAIT cycles after SETTLE; the next job then completes normally.
- rst asserted during WAIT of a job with n=20 → no resp_valid, busy=0 next cycle. Afterwards req[2] is granted before req[3] (pointer back at 0).
